// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline controller: FSM states, stage
// indices and the architectural NOP used when a pipeline register is cleared.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    // PA-RISC canonical NOP: OR r0,r0,r0
    localparam logic [31:0] NOP_INSN = 32'h0800_0240;

    function automatic int unsigned wait_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline controller: merges load-use stalls, taken-branch redirects and
// data-memory wait states into per-stage enables, clears and valid bits.
module pipeline_sequencer
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_nop,
    input  logic             hz_le,
    input  logic             br_taken,
    input  logic             br_nullify,
    input  logic             mem_busy,
    output logic             pc_le,
    output logic             pc_sel,
    output logic             tgt_le,
    output logic             if_id_le,
    output logic             if_id_clr,
    output logic             id_ex_le,
    output logic             id_ex_clr,
    output logic             ex_mem_le,
    output logic             mem_wb_le,
    output logic             v_id,
    output logic             v_ex,
    output logic             v_mem,
    output logic             v_wb,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned          WAIT_W   = wait_width(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_pend;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic                   r_mem_err;
    logic [STG_WB:STG_ID]   r_v;

    logic w_in_wait;
    logic w_timeout;
    logic w_release;
    logic w_freeze;
    logic w_pend;
    logic w_br;
    logic w_stall;
    logic w_redir;
    logic w_stall_inc;

    assign w_in_wait = (r_state == ST_MEM_WAIT);
    assign w_timeout = w_in_wait && (r_wait_cnt == WAIT_MAX);
    assign w_release = w_in_wait && (!mem_busy || w_timeout);

    // A timed-out wait releases exactly like a normal one, so busy is masked out.
    assign w_freeze  = (((r_state == ST_RUN) || (r_state == ST_REDIRECT)) && mem_busy)
                     || (w_in_wait && !w_release);

    assign w_pend    = (r_state == ST_REDIRECT) || (w_in_wait && r_pend);
    assign w_br      = br_taken && r_v[STG_EX] && !w_pend;
    assign w_stall   = hz_nop && r_v[STG_ID] && !(w_br && br_nullify);
    assign w_redir   = w_br || w_pend;

    always_comb begin
        pc_le     = 1'b0;
        pc_sel    = 1'b0;
        tgt_le    = 1'b0;
        if_id_le  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_le  = 1'b0;
        id_ex_clr = 1'b0;
        ex_mem_le = 1'b0;
        mem_wb_le = 1'b0;
        w_next    = r_state;
        if (r_state == ST_INIT) begin
            w_next = ST_RUN;
        end else if (w_freeze) begin
            mem_wb_le = 1'b1;
            w_next    = ST_MEM_WAIT;
        end else if (w_stall) begin
            id_ex_le  = 1'b1;
            id_ex_clr = 1'b1;
            ex_mem_le = 1'b1;
            mem_wb_le = 1'b1;
            tgt_le    = w_br;
            w_next    = w_redir ? ST_REDIRECT : ST_RUN;
        end else begin
            pc_le     = 1'b1;
            if_id_le  = 1'b1;
            id_ex_le  = 1'b1;
            ex_mem_le = 1'b1;
            mem_wb_le = 1'b1;
            pc_sel    = w_redir;
            if_id_clr = w_redir;
            tgt_le    = w_br;
            id_ex_clr = w_br && br_nullify;
            w_next    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_pend     <= 1'b0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
            r_v        <= '0;
        end else begin
            r_state   <= w_next;
            r_mem_err <= r_mem_err || w_timeout;
            // Pending redirect is parked in r_pend for the whole wait.
            if (w_freeze) begin
                r_pend     <= w_pend;
                r_wait_cnt <= w_in_wait ? (r_wait_cnt + WAIT_W'(1)) : '0;
            end else begin
                r_pend     <= 1'b0;
                r_wait_cnt <= '0;
            end
            if (if_id_le)  r_v[STG_ID]  <= !if_id_clr;
            if (id_ex_le)  r_v[STG_EX]  <= r_v[STG_ID] && !id_ex_clr;
            if (ex_mem_le) r_v[STG_MEM] <= r_v[STG_EX];
            if (mem_wb_le) r_v[STG_WB]  <= r_v[STG_MEM] && !w_freeze;
        end
    end

    assign w_stall_inc = !pc_le && (r_state != ST_INIT);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    assign v_id    = r_v[STG_ID];
    assign v_ex    = r_v[STG_EX];
    assign v_mem   = r_v[STG_MEM];
    assign v_wb    = r_v[STG_WB];
    assign mem_err = r_mem_err;
    assign state   = r_state;

    a_hz_le: assert property (@(posedge clk) disable iff (!rst_n) hz_le == !hz_nop);

endmodule
